// File: rtl/reg_file_sb_if.sv
// Bus between the ToyCPU issue/write-back stages and the register file scoreboard.
// master drives reads, issue marking and write-back; slave is the register file.
interface reg_file_sb_if #(
    parameter int XLEN = 32,
    parameter int AW   = 5,
    parameter int NRD  = 2,
    parameter int TAGW = 4
) ();
    logic                 rdy_in;
    logic [NRD*AW-1:0]    rd_addr;
    logic [NRD*XLEN-1:0]  rd_data;
    logic [NRD-1:0]       rd_busy;
    logic [NRD*TAGW-1:0]  rd_tag;
    logic                 iss_valid;
    logic [AW-1:0]        iss_rd;
    logic [TAGW-1:0]      iss_tag;
    logic                 wb_valid;
    logic [AW-1:0]        wb_rd;
    logic [TAGW-1:0]      wb_tag;
    logic [XLEN-1:0]      wb_data;
    logic                 flush;
    logic [AW:0]          busy_count;

    modport master (
        output rdy_in, rd_addr, iss_valid, iss_rd, iss_tag,
               wb_valid, wb_rd, wb_tag, wb_data, flush,
        input  rd_data, rd_busy, rd_tag, busy_count
    );

    modport slave (
        input  rdy_in, rd_addr, iss_valid, iss_rd, iss_tag,
               wb_valid, wb_rd, wb_tag, wb_data, flush,
        output rd_data, rd_busy, rd_tag, busy_count
    );
endinterface

// File: rtl/reg_file_sb.sv
// Register file with per-register busy/tag scoreboard: NRD bypassed read ports,
// one tagged write-back port, one issue port and a flush of all pending producers.
module reg_file_sb #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int AW   = $clog2(NREG),
    parameter int NRD  = 2,
    parameter int TAGW = 4
) (
    input logic         clk,
    input logic         rst,
    reg_file_sb_if.slave bus
);

    localparam logic [AW:0] NREG_W = (AW+1)'(NREG);

    logic [XLEN-1:0] data    [NREG];
    logic [TAGW-1:0] tag     [NREG];
    logic [TAGW-1:0] tag_nxt [NREG];
    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_nxt;
    logic [AW:0]     cnt;
    logic [AW:0]     cnt_nxt;
    logic            wb_we;
    logic            iss_we;

    // x0 and indices beyond NREG are never written, issued or reported busy.
    function automatic logic writable(input logic [AW-1:0] a);
        return (a != '0) && ({1'b0, a} < NREG_W);
    endfunction

    assign wb_we  = bus.rdy_in && bus.wb_valid  && writable(bus.wb_rd);
    assign iss_we = bus.rdy_in && bus.iss_valid && writable(bus.iss_rd);

    assign bus.busy_count = cnt;

    // Read ports: a write-back in flight is forwarded; a same-cycle issue is not.
    always_comb begin
        logic [AW-1:0]   a;
        logic [XLEN-1:0] d;
        logic            b;
        logic [TAGW-1:0] t;
        // NOTE: every combinational output and temporary gets a default first so no latch is inferred.
        bus.rd_data = '0;
        bus.rd_busy = '0;
        bus.rd_tag  = '0;
        a = '0;
        d = '0;
        b = 1'b0;
        t = '0;
        for (int p = 0; p < NRD; p++) begin
            a = bus.rd_addr[p*AW +: AW];
            d = '0;
            b = 1'b0;
            t = '0;
            if (writable(a)) begin
                d = data[a];
                b = busy[a];
                t = tag[a];
                if (wb_we && bus.wb_rd == a) begin
                    d = bus.wb_data;
                    if (bus.wb_tag == tag[a]) b = 1'b0;
                end
            end
            if (!b) t = '0;
            bus.rd_data[p*XLEN +: XLEN] = d;
            bus.rd_busy[p]              = b;
            bus.rd_tag[p*TAGW +: TAGW]  = t;
        end
    end

    // Scoreboard next state: flush beats issue; issue beats a matching write-back.
    always_comb begin
        busy_nxt = busy;
        tag_nxt  = tag;
        if (bus.flush) begin
            busy_nxt = '0;
            tag_nxt  = '{default: '0};
        end else begin
            if (wb_we && busy[bus.wb_rd] && bus.wb_tag == tag[bus.wb_rd])
                busy_nxt[bus.wb_rd] = 1'b0;
            if (iss_we) begin
                busy_nxt[bus.iss_rd] = 1'b1;
                tag_nxt[bus.iss_rd]  = bus.iss_tag;
            end
        end
        cnt_nxt = '0;
        for (int i = 0; i < NREG; i++)
            cnt_nxt = cnt_nxt + (AW+1)'(busy_nxt[i]);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            // NOTE: the data array is reset on purpose: reads after reset must return zero.
            for (int i = 0; i < NREG; i++) begin
                data[i] <= '0;
                tag[i]  <= '0;
            end
            busy <= '0;
            cnt  <= '0;
        end else if (bus.rdy_in) begin
            if (wb_we) data[bus.wb_rd] <= bus.wb_data;
            busy <= busy_nxt;
            tag  <= tag_nxt;
            cnt  <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: bypass, stale tags, issue/wb/flush collisions,
// rdy_in hold and mid-run reset, with hand-computed expectations.
module tb_reg_file_sb;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    reg_file_sb_if #(.XLEN(32), .AW(5), .NRD(2), .TAGW(4)) bus ();

    reg_file_sb #(.XLEN(32), .NREG(32), .AW(5), .NRD(2), .TAGW(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.wb_valid  = 1'b0;
        bus.wb_rd     = '0;
        bus.wb_tag    = '0;
        bus.wb_data   = '0;
        bus.iss_valid = 1'b0;
        bus.iss_rd    = '0;
        bus.iss_tag   = '0;
        bus.flush     = 1'b0;
    endtask

    task automatic wb(input logic [4:0] r, input logic [3:0] t, input logic [31:0] d);
        bus.wb_valid = 1'b1;
        bus.wb_rd    = r;
        bus.wb_tag   = t;
        bus.wb_data  = d;
    endtask

    task automatic iss(input logic [4:0] r, input logic [3:0] t);
        bus.iss_valid = 1'b1;
        bus.iss_rd    = r;
        bus.iss_tag   = t;
    endtask

    task automatic rd_chk(input string nm, input int p, input logic [4:0] a,
                          input logic [31:0] ed, input logic eb, input logic [3:0] et);
        bus.rd_addr[p*5 +: 5] = a;
        #1;
        check({nm, ".data"}, 64'(bus.rd_data[p*32 +: 32]), 64'(ed));
        check({nm, ".busy"}, 64'(bus.rd_busy[p]),          64'(eb));
        check({nm, ".tag"},  64'(bus.rd_tag[p*4 +: 4]),    64'(et));
    endtask

    task automatic cnt_chk(input string nm, input logic [5:0] e);
        check({nm, ".count"}, 64'(bus.busy_count), 64'(e));
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b0;
        bus.rdy_in  = 1'b1;
        bus.rd_addr = '0;
        idle();
        step();
        step();

        // Reset state on every index, both ports.
        for (int i = 0; i < 32; i++) begin
            rd_chk("rst_p0", 0, 5'(i), 32'h0, 1'b0, 4'h0);
            rd_chk("rst_p1", 1, 5'(31 - i), 32'h0, 1'b0, 4'h0);
        end
        cnt_chk("rst", 6'd0);
        rst = 1'b1;
        step();

        // Write-back bypass, then storage read.
        wb(5'd5, 4'd0, 32'hDEADBEEF);
        rd_chk("x5_bypass", 0, 5'd5, 32'hDEADBEEF, 1'b0, 4'h0);
        step();
        idle();
        rd_chk("x5_stored", 0, 5'd5, 32'hDEADBEEF, 1'b0, 4'h0);

        // x0 ignores write and issue.
        wb(5'd0, 4'd3, 32'h1234);
        iss(5'd0, 4'd3);
        rd_chk("x0_same", 0, 5'd0, 32'h0, 1'b0, 4'h0);
        step();
        idle();
        rd_chk("x0_next", 1, 5'd0, 32'h0, 1'b0, 4'h0);
        cnt_chk("x0", 6'd0);

        // Re-issue overwrites tag; stale write-back keeps register busy.
        iss(5'd3, 4'd2);
        step();
        cnt_chk("x3_iss2", 6'd1);
        iss(5'd3, 4'd7);
        step();
        idle();
        rd_chk("x3_reiss", 0, 5'd3, 32'h0, 1'b1, 4'd7);
        cnt_chk("x3_reiss", 6'd1);
        wb(5'd3, 4'd2, 32'h11);
        rd_chk("x3_stale_byp", 0, 5'd3, 32'h11, 1'b1, 4'd7);
        step();
        idle();
        rd_chk("x3_stale", 0, 5'd3, 32'h11, 1'b1, 4'd7);
        cnt_chk("x3_stale", 6'd1);
        wb(5'd3, 4'd7, 32'h22);
        rd_chk("x3_match_byp", 1, 5'd3, 32'h22, 1'b0, 4'h0);
        step();
        idle();
        rd_chk("x3_match", 1, 5'd3, 32'h22, 1'b0, 4'h0);
        cnt_chk("x3_match", 6'd0);

        // Same-cycle issue and matching write-back: issue wins.
        iss(5'd4, 4'd1);
        step();
        iss(5'd4, 4'd5);
        wb(5'd4, 4'd1, 32'hAA);
        rd_chk("x4_same", 1, 5'd4, 32'hAA, 1'b0, 4'h0);
        step();
        idle();
        rd_chk("x4_next", 1, 5'd4, 32'hAA, 1'b1, 4'd5);
        cnt_chk("x4_next", 6'd1);
        wb(5'd4, 4'd5, 32'hAB);
        step();
        idle();
        cnt_chk("x4_clear", 6'd0);

        // Flush with same-cycle write-back and issue.
        iss(5'd1, 4'd1);
        step();
        iss(5'd2, 4'd2);
        step();
        iss(5'd6, 4'd3);
        step();
        idle();
        cnt_chk("pre_flush", 6'd3);
        rd_chk("x2_pre_flush", 0, 5'd2, 32'h0, 1'b1, 4'd2);
        bus.flush = 1'b1;
        wb(5'd2, 4'd9, 32'h77);
        iss(5'd9, 4'd4);
        step();
        idle();
        cnt_chk("flush", 6'd0);
        rd_chk("x2_flush", 0, 5'd2, 32'h77, 1'b0, 4'h0);
        rd_chk("x9_flush", 1, 5'd9, 32'h0, 1'b0, 4'h0);
        rd_chk("x1_flush", 0, 5'd1, 32'h0, 1'b0, 4'h0);
        rd_chk("x6_flush", 1, 5'd6, 32'h0, 1'b0, 4'h0);

        // rdy_in low: nothing changes and no bypass.
        iss(5'd10, 4'd3);
        step();
        idle();
        cnt_chk("x10_iss", 6'd1);
        bus.rdy_in = 1'b0;
        wb(5'd7, 4'd0, 32'h5555);
        iss(5'd8, 4'd6);
        bus.flush = 1'b1;
        for (int c = 0; c < 3; c++) begin
            rd_chk("hold_x7", 0, 5'd7, 32'h0, 1'b0, 4'h0);
            rd_chk("hold_x10", 1, 5'd10, 32'h0, 1'b1, 4'd3);
            cnt_chk("hold", 6'd1);
            step();
        end
        rd_chk("hold_x8", 0, 5'd8, 32'h0, 1'b0, 4'h0);
        idle();
        bus.rdy_in = 1'b1;
        rd_chk("hold_x7_after", 0, 5'd7, 32'h0, 1'b0, 4'h0);

        // Mid-run reset drops pending producers and data.
        rst = 1'b0;
        step();
        rst = 1'b1;
        cnt_chk("mid_rst", 6'd0);
        rd_chk("mid_rst_x10", 1, 5'd10, 32'h0, 1'b0, 4'h0);
        rd_chk("mid_rst_x5", 0, 5'd5, 32'h0, 1'b0, 4'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
